// File: rtl/stepper_move_controller.sv
// Two-axis stepper command sequencer: one move/home command at a time, tick-paced
// step strobes, limit-switch interlock toward home, and per-axis position tracking.
module stepper_move_controller #(
  parameter int TICK_DIV = 100000,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_axis,
  input  logic             cmd_dir,
  input  logic             cmd_home,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             stop,
  input  logic [1:0]       limit,
  output logic [1:0]       dir,
  output logic [1:0]       en,
  output logic [1:0]       step,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] pos0,
  output logic [CNT_W-1:0] pos1
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MOVE = 2'd1;
  localparam logic [1:0] ST_HOME = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [TW-1:0]    r_tick;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] r_pos0;
  logic [CNT_W-1:0] r_pos1;
  logic             r_axis;
  logic [1:0]       r_dir;
  logic [1:0]       r_en;
  logic [1:0]       r_step;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;

  logic             w_tick;
  logic             w_lim;
  logic             w_dir;
  logic [CNT_W-1:0] w_pos_cur;
  logic [CNT_W-1:0] w_pos_next;

  assign w_tick = (r_tick == TICK_MAX);
  assign w_lim  = limit[r_axis];
  assign w_dir  = r_dir[r_axis];

  // Position of the addressed axis after one step in the latched direction.
  always_comb begin
    w_pos_cur = r_axis ? r_pos1 : r_pos0;
    if (w_dir) begin
      w_pos_next = w_pos_cur + CNT_W'(1);
    end else begin
      w_pos_next = w_pos_cur - CNT_W'(1);
    end
  end

  // Command sequencer; reset is asynchronous so en/step drop without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_tick    <= '0;
      r_rem     <= '0;
      r_pos0    <= '0;
      r_pos1    <= '0;
      r_axis    <= 1'b0;
      r_dir     <= 2'b00;
      r_en      <= 2'b00;
      r_step    <= 2'b00;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_step <= 2'b00;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && r_ready) begin
            r_axis          <= cmd_axis;
            r_dir[cmd_axis] <= cmd_home ? 1'b0 : cmd_dir;
            r_en[cmd_axis]  <= 1'b1;
            // Homing reuses the step counter as its timeout budget.
            r_rem           <= cmd_home ? {CNT_W{1'b1}} : cmd_steps;
            r_tick          <= '0;
            r_aborted       <= 1'b0;
            r_busy          <= 1'b1;
            r_ready         <= 1'b0;
            r_state         <= cmd_home ? ST_HOME : ST_MOVE;
          end
        end
        ST_MOVE, ST_HOME: begin
          r_tick <= w_tick ? '0 : r_tick + TW'(1);
          if (stop) begin
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end else if (r_rem == '0) begin
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_aborted <= (r_state == ST_HOME);
          end else if (w_tick) begin
            if (w_lim && (r_state == ST_HOME)) begin
              r_state   <= ST_DONE;
              r_done    <= 1'b1;
              r_aborted <= 1'b0;
              if (r_axis) r_pos1 <= '0;
              else        r_pos0 <= '0;
            end else if (w_lim && !w_dir) begin
              r_state   <= ST_DONE;
              r_done    <= 1'b1;
              r_aborted <= 1'b1;
            end else begin
              r_step[r_axis] <= 1'b1;
              r_rem          <= r_rem - CNT_W'(1);
              if (r_axis) r_pos1 <= w_pos_next;
              else        r_pos0 <= w_pos_next;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_en    <= 2'b00;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_en    <= 2'b00;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign dir       = r_dir;
  assign en        = r_en;
  assign step      = r_step;
  assign busy      = r_busy;
  assign done      = r_done;
  assign aborted   = r_aborted;
  assign pos0      = r_pos0;
  assign pos1      = r_pos1;

endmodule

// File: tb/tb_stepper_move_controller.sv
// Directed bench for stepper_move_controller with TICK_DIV=4, CNT_W=16.
module tb_stepper_move_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_axis;
  logic        cmd_dir;
  logic        cmd_home;
  logic [15:0] cmd_steps;
  logic        stop;
  logic [1:0]  limit;
  logic [1:0]  dir;
  logic [1:0]  en;
  logic [1:0]  step;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] pos0;
  logic [15:0] pos1;

  int checks   = 0;
  int failures = 0;

  int   nst, first, last, dcyc, found;
  bit   gap_ok, other_bad;
  logic ab;

  stepper_move_controller #(.TICK_DIV(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_axis(cmd_axis), .cmd_dir(cmd_dir), .cmd_home(cmd_home),
    .cmd_steps(cmd_steps), .stop(stop), .limit(limit), .dir(dir), .en(en),
    .step(step), .busy(busy), .done(done), .aborted(aborted),
    .pos0(pos0), .pos1(pos1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command for one accepting edge, then withdraw it; returns #1 after the edge.
  task automatic issue(input logic ax, input logic d, input logic h, input logic [15:0] n);
    @(negedge clk);
    cmd_axis = ax; cmd_dir = d; cmd_home = h; cmd_steps = n; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Observe strobes on axis ax until done; optionally raise limit[ax] after lim_after strobes.
  task automatic watch(input int ax, input int maxc, input int lim_after,
                       output int n, output int f, output int l, output bit gok,
                       output int dc, output logic abo, output bit obad);
    n = 0; f = -1; l = -1; gok = 1'b1; dc = -1; abo = 1'b0; obad = 1'b0;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (step[1-ax]) obad = 1'b1;
      if (step[ax]) begin
        if (n == 0) f = c;
        else if (c - l != 4) gok = 1'b0;
        l = c;
        n++;
        if (n == lim_after) limit[ax] = 1'b1;
      end
      if (done) begin
        dc = c; abo = aborted;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_axis = 1'b0; cmd_dir = 1'b0; cmd_home = 1'b0;
    cmd_steps = 16'd0; stop = 1'b0; limit = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_dir",   32'(dir), 32'd0);
    chk("rst_en",    32'(en), 32'd0);
    chk("rst_step",  32'(step), 32'd0);
    chk("rst_busy_done_ab", {29'd0, busy, done, aborted}, 32'd0);
    chk("rst_pos",   {pos1, pos0}, 32'd0);
    rst = 1'b0;

    // Move axis 0 away from home by 3
    issue(1'b0, 1'b1, 1'b0, 16'd3);
    chk("m1_busy",  32'(busy), 32'd1);
    chk("m1_ready", 32'(cmd_ready), 32'd0);
    chk("m1_en",    32'(en), 32'd1);
    chk("m1_dir",   32'(dir), 32'd1);
    watch(0, 40, 0, nst, first, last, gap_ok, dcyc, ab, other_bad);
    chk("m1_nsteps", 32'(nst), 32'd3);
    chk("m1_first_ge4", 32'(first >= 4), 32'd1);
    chk("m1_gap4", 32'(gap_ok), 32'd1);
    chk("m1_done_after_last", 32'(dcyc), 32'(last + 1));
    chk("m1_aborted", 32'(ab), 32'd0);
    chk("m1_other_axis", 32'(other_bad), 32'd0);
    chk("m1_pos0", 32'(pos0), 32'd3);
    @(negedge clk);
    chk("m1_en_after", 32'(en), 32'd0);
    chk("m1_ready_after", 32'(cmd_ready), 32'd1);
    chk("m1_idle_busy_done", {30'd0, busy, done}, 32'd0);

    // Axis 1 toward home, limit after 2nd strobe
    issue(1'b1, 1'b0, 1'b0, 16'd10);
    chk("m2_en",  32'(en), 32'd2);
    chk("m2_dir_hold", 32'(dir), 32'd1);
    watch(1, 80, 2, nst, first, last, gap_ok, dcyc, ab, other_bad);
    chk("m2_nsteps", 32'(nst), 32'd2);
    chk("m2_done_next_tick", 32'(dcyc), 32'(last + 4));
    chk("m2_aborted", 32'(ab), 32'd1);
    chk("m2_pos1", 32'(pos1), 32'hFFFE);
    limit = 2'b00;

    // Bring axis 0 to 5, then home it
    issue(1'b0, 1'b1, 1'b0, 16'd2);
    watch(0, 40, 0, nst, first, last, gap_ok, dcyc, ab, other_bad);
    chk("m3_pos0", 32'(pos0), 32'd5);
    issue(1'b0, 1'b1, 1'b1, 16'd1);
    chk("h_dir", 32'(dir), 32'd0);
    chk("h_en",  32'(en), 32'd1);
    watch(0, 100, 7, nst, first, last, gap_ok, dcyc, ab, other_bad);
    chk("h_nsteps", 32'(nst), 32'd7);
    chk("h_gap4", 32'(gap_ok), 32'd1);
    chk("h_done_next_tick", 32'(dcyc), 32'(last + 4));
    chk("h_aborted", 32'(ab), 32'd0);
    chk("h_pos0", 32'(pos0), 32'd0);
    issue(1'b0, 1'b1, 1'b0, 16'd2);
    watch(0, 40, 0, nst, first, last, gap_ok, dcyc, ab, other_bad);
    chk("off_home_nsteps", 32'(nst), 32'd2);
    chk("off_home_aborted", 32'(ab), 32'd0);
    chk("off_home_pos0", 32'(pos0), 32'd2);
    limit = 2'b00;

    // Stop coincident with the second tick of a 5-step move
    issue(1'b0, 1'b1, 1'b0, 16'd5);
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (step[0]) begin found = 1; break; end
    end
    chk("stop_first_strobe_seen", 32'(found), 32'd1);
    repeat (3) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_no_strobe", 32'(step), 32'd0);
    chk("stop_done", 32'(done), 32'd1);
    chk("stop_aborted", 32'(aborted), 32'd1);
    chk("stop_pos0", 32'(pos0), 32'd3);

    // Zero-step command followed by a held-valid second command
    @(negedge clk);
    cmd_axis = 1'b1; cmd_dir = 1'b1; cmd_home = 1'b0; cmd_steps = 16'd0; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_steps = 16'd1;
    chk("z_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("z_c1_step_done", {30'd0, step[0] | step[1], done}, 32'd0);
    @(negedge clk);
    chk("z_c2_done", 32'(done), 32'd1);
    chk("z_c2_aborted", 32'(aborted), 32'd0);
    chk("z_c2_step", 32'(step), 32'd0);
    chk("z_c2_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("z_c3_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_en", 32'(en), 32'd2);
    chk("b2b_dir", 32'(dir), 32'd3);
    watch(1, 40, 0, nst, first, last, gap_ok, dcyc, ab, other_bad);
    chk("b2b_nsteps", 32'(nst), 32'd1);
    chk("b2b_pos1", 32'(pos1), 32'hFFFF);

    // Reset pulsed while a strobe is high
    issue(1'b0, 1'b1, 1'b0, 16'd5);
    found = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (step[0]) begin found = 1; break; end
    end
    chk("r_pre_step", 32'(step), 32'd1);
    rst = 1'b1;
    #1;
    chk("r_async_step", 32'(step), 32'd0);
    chk("r_async_en", 32'(en), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    found = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) found = 1;
    end
    chk("r_no_done", 32'(found), 32'd0);
    chk("r_ready", 32'(cmd_ready), 32'd1);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_pos", {pos1, pos0}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
